hb_decim_ctrl: RTL and testbench
================================

HB_DECIM_CTRL -- requirements
Module: hb_decim_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, I/Q sample width.
REQ-002 Parameter FLUSH_CYCLES, default 4, number of cycles o_chain_reset is held per flush.
REQ-003 Parameter SETTLE_SAMPLES, default 16, number of chain output samples discarded after a flush.
REQ-004 i_clock  in  1  sole clock, rising edge.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 i_rate_sel  in  2  requested decimation 2^i_rate_sel (0..3 → 1,2,4,8).
REQ-007 i_rate_load  in  1  one-cycle strobe; latches i_rate_sel.
REQ-008 i_valid  in  1  input sample strobe from upstream.
REQ-009 o_chain_in_valid  out  1  gated input strobe to the halfband cascade.
REQ-010 o_chain_reset  out  1  synchronous reset to all cascade stages.
REQ-011 o_stage_en  out  3  per-stage enable; bit k=1 means stage k decimates, 0 means bypass.
REQ-012 i_chain_inph, i_chain_quad  in  WIDTH each  cascade output I/Q.
REQ-013 i_chain_valid  in  1  cascade output strobe.
REQ-014 o_inph_data, o_quad_data  out  WIDTH each  gated, registered output I/Q.
REQ-015 o_valid  out  1  output strobe.
REQ-016 o_busy  out  1  high in FLUSH or SETTLE.
REQ-017 o_rate_ack  out  1  one-cycle pulse on entry to RUN.
REQ-018 o_drop_count  out  16  saturating count of i_valid samples dropped during FLUSH.

Function
REQ-019 The FSM SHALL have three states: FLUSH, SETTLE, RUN.
REQ-020 FLUSH: o_chain_reset=1 for exactly FLUSH_CYCLES cycles, then go to SETTLE.
REQ-021 SETTLE: count i_chain_valid pulses; after the SETTLE_SAMPLES-th pulse, go to RUN next cycle; these pulses never produce o_valid.
REQ-022 RUN: o_valid/o_inph_data/o_quad_data SHALL equal i_chain_valid/i_chain_inph/i_chain_quad delayed by exactly one cycle.
REQ-023 o_data SHALL hold its last value when o_valid=0.
REQ-024 An i_rate_load in any state SHALL latch i_rate_sel and force FLUSH on the next cycle, restarting the flush and settle counters; the same rate reloaded in RUN still re-flushes.
REQ-025 o_stage_en SHALL be thermometer-coded from the latched rate (0→000, 1→001, 2→011, 3→111) and update on the cycle FLUSH is entered.
REQ-026 o_chain_in_valid = i_valid AND state≠FLUSH (combinational).
REQ-027 Each i_valid=1 cycle in FLUSH SHALL increment o_drop_count, saturating at 0xFFFF; only reset clears it.
REQ-028 o_rate_ack SHALL pulse exactly once per SETTLE→RUN transition, and not at all if a reload aborts SETTLE.
REQ-029 i_chain_valid in the cycle of an i_rate_load SHALL be discarded.
REQ-030 SETTLE_SAMPLES=0 SHALL go FLUSH→SETTLE→RUN with one SETTLE cycle.

Reset
REQ-031 On i_reset: state=FLUSH, latched rate=0, o_stage_en=000, counters=0, o_valid=0, o_data=0, o_rate_ack=0, o_drop_count=0.
REQ-032 o_chain_reset SHALL also be 1 while i_reset=1; the FLUSH_CYCLES count begins on the first cycle after i_reset deasserts.
REQ-033 Reset asserted mid-operation SHALL override any simultaneous i_rate_load.

Structure
REQ-034 A shared package hb_decim_pkg SHALL hold the state enum (FLUSH, SETTLE, RUN), the rate-to-stage_en function and the MAX_STAGES=3 constant.
REQ-035 The block SHALL be one module with no sub-modules; the cascade is instantiated by the parent.

Verification
REQ-036 Reset released, no i_valid: o_chain_reset high 4 cycles, then o_busy until 16 chain pulses occur, then o_rate_ack once, o_stage_en=000.
REQ-037 Load rate 2 in RUN with chain valid every 4th cycle: o_stage_en=011 next cycle; first 16 chain samples suppressed; sample 17 appears on o_valid 1 cycle later with matching data.
REQ-038 i_valid held high through a flush: o_chain_in_valid low for 4 cycles; o_drop_count increases by 4.
REQ-039 Reload during SETTLE after 10 chain pulses: FLUSH restarts; the next o_rate_ack comes only after 16 fresh pulses; no o_valid in between.
REQ-040 Force 70000 dropped samples (repeated reloads): o_drop_count stops at 0xFFFF.
REQ-041 i_reset together with i_rate_load=1, i_rate_sel=3: after reset the latched rate is 0 and o_stage_en=000.

Source files
------------

// File: rtl/hb_decim_pkg.sv
// Shared types and helpers for the halfband decimator cascade controller.
package hb_decim_pkg;

  localparam int MAX_STAGES = 3;

  typedef enum logic [1:0] {
    FLUSH  = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_t;

  // Thermometer code: rate r enables the first r halfband stages.
  function automatic logic [MAX_STAGES-1:0] rate_to_stage_en(input logic [1:0] rate);
    logic [MAX_STAGES-1:0] en;
    case (rate)
      2'd0:    en = 3'b000;
      2'd1:    en = 3'b001;
      2'd2:    en = 3'b011;
      default: en = 3'b111;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/hb_decim_ctrl.sv
// Rate-change sequencer for a halfband cascade: flush, discard settling samples, then pass data.
// Output data/valid lag the cascade by one cycle; drops input strobes while flushing.
module hb_decim_ctrl
  import hb_decim_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int FLUSH_CYCLES   = 4,
  parameter int SETTLE_SAMPLES = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [1:0]            i_rate_sel,
  input  logic                  i_rate_load,
  input  logic                  i_valid,
  output logic                  o_chain_in_valid,
  output logic                  o_chain_reset,
  output logic [MAX_STAGES-1:0] o_stage_en,
  input  logic [WIDTH-1:0]      i_chain_inph,
  input  logic [WIDTH-1:0]      i_chain_quad,
  input  logic                  i_chain_valid,
  output logic [WIDTH-1:0]      o_inph_data,
  output logic [WIDTH-1:0]      o_quad_data,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic                  o_rate_ack,
  output logic [15:0]           o_drop_count
);

  localparam int FLUSH_LAST  = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 1 : 0;
  localparam int FCW         = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int SETTLE_LAST = (SETTLE_SAMPLES > 1) ? SETTLE_SAMPLES - 1 : 0;
  localparam int SCW         = (SETTLE_SAMPLES > 2) ? $clog2(SETTLE_SAMPLES) : 1;

  state_t            r_state;
  state_t            w_next;
  logic [FCW-1:0]    r_flush_cnt;
  logic [SCW-1:0]    r_settle_cnt;
  logic [1:0]        r_rate;
  logic              r_valid;
  logic [WIDTH-1:0]  r_inph;
  logic [WIDTH-1:0]  r_quad;
  logic              r_rate_ack;
  logic [15:0]       r_drop_cnt;
  logic              w_flush_done;
  logic              w_settle_done;

  assign w_flush_done  = (r_flush_cnt == FCW'(FLUSH_LAST));
  // With no settling samples requested, SETTLE lasts exactly one cycle.
  assign w_settle_done = (SETTLE_SAMPLES == 0) ||
                         (i_chain_valid && (r_settle_cnt == SCW'(SETTLE_LAST)));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= FLUSH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (i_rate_load) begin
      w_next = FLUSH;
    end else begin
      case (r_state)
        FLUSH:   if (w_flush_done)  w_next = SETTLE;
        SETTLE:  if (w_settle_done) w_next = RUN;
        RUN:     w_next = RUN;
        default: w_next = FLUSH;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_flush_cnt  <= '0;
      r_settle_cnt <= '0;
    end else begin
      if (r_state == FLUSH && w_next == FLUSH && !i_rate_load) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end else begin
        r_flush_cnt <= '0;
      end

      if (r_state != SETTLE || w_next != SETTLE) begin
        r_settle_cnt <= '0;
      end else if (i_chain_valid) begin
        r_settle_cnt <= r_settle_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rate     <= 2'd0;
      r_rate_ack <= 1'b0;
      r_drop_cnt <= 16'd0;
    end else begin
      if (i_rate_load) begin
        r_rate <= i_rate_sel;
      end
      r_rate_ack <= (r_state == SETTLE) && (w_next == RUN);
      if (r_state == FLUSH && i_valid && r_drop_cnt != 16'hFFFF) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  // A cascade sample arriving alongside a reload belongs to the old rate.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_inph  <= '0;
      r_quad  <= '0;
    end else begin
      r_valid <= (r_state == RUN) && i_chain_valid && !i_rate_load;
      if ((r_state == RUN) && i_chain_valid && !i_rate_load) begin
        r_inph <= i_chain_inph;
        r_quad <= i_chain_quad;
      end
    end
  end

  assign o_chain_in_valid = i_valid && (r_state != FLUSH);
  assign o_chain_reset    = i_reset || (r_state == FLUSH);
  assign o_stage_en       = rate_to_stage_en(r_rate);
  assign o_inph_data      = r_inph;
  assign o_quad_data      = r_quad;
  assign o_valid          = r_valid;
  assign o_busy           = (r_state != RUN);
  assign o_rate_ack       = r_rate_ack;
  assign o_drop_count     = r_drop_cnt;

endmodule

// File: tb/tb_hb_decim_ctrl.sv
// Directed bench for hb_decim_ctrl; a second instance covers the zero-settle configuration.
module tb_hb_decim_ctrl;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [1:0]  i_rate_sel = 2'd0;
  logic        i_rate_load = 1'b0;
  logic        i_valid = 1'b0;
  logic [15:0] i_chain_inph = 16'd0;
  logic [15:0] i_chain_quad = 16'd0;
  logic        i_chain_valid = 1'b0;

  logic        o_chain_in_valid, o_chain_reset, o_valid, o_busy, o_rate_ack;
  logic [2:0]  o_stage_en;
  logic [15:0] o_inph_data, o_quad_data, o_drop_count;

  logic        z_chain_in_valid, z_chain_reset, z_valid, z_busy, z_rate_ack;
  logic [2:0]  z_stage_en;
  logic [15:0] z_inph_data, z_quad_data, z_drop_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hb_decim_ctrl u_dut (
    .i_clock(clk), .i_reset(i_reset), .i_rate_sel(i_rate_sel), .i_rate_load(i_rate_load),
    .i_valid(i_valid), .o_chain_in_valid(o_chain_in_valid), .o_chain_reset(o_chain_reset),
    .o_stage_en(o_stage_en), .i_chain_inph(i_chain_inph), .i_chain_quad(i_chain_quad),
    .i_chain_valid(i_chain_valid), .o_inph_data(o_inph_data), .o_quad_data(o_quad_data),
    .o_valid(o_valid), .o_busy(o_busy), .o_rate_ack(o_rate_ack), .o_drop_count(o_drop_count)
  );

  hb_decim_ctrl #(.WIDTH(16), .FLUSH_CYCLES(4), .SETTLE_SAMPLES(0)) u_dut_z (
    .i_clock(clk), .i_reset(i_reset), .i_rate_sel(i_rate_sel), .i_rate_load(i_rate_load),
    .i_valid(i_valid), .o_chain_in_valid(z_chain_in_valid), .o_chain_reset(z_chain_reset),
    .o_stage_en(z_stage_en), .i_chain_inph(i_chain_inph), .i_chain_quad(i_chain_quad),
    .i_chain_valid(i_chain_valid), .o_inph_data(z_inph_data), .o_quad_data(z_quad_data),
    .o_valid(z_valid), .o_busy(z_busy), .o_rate_ack(z_rate_ack), .o_drop_count(z_drop_count)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] di, input logic [15:0] dq);
    i_chain_valid = 1'b1;
    i_chain_inph  = di;
    i_chain_quad  = dq;
    tick();
    i_chain_valid = 1'b0;
  endtask

  // n cascade pulses during SETTLE, each followed by gap idle cycles.
  task automatic run_settle(input int n, input int gap, input logic ack_last);
    for (int k = 0; k < n; k++) begin
      chk("settle_busy", {31'd0, o_busy}, 32'd1);
      send(16'(k), ~16'(k));
      chk("settle_vld", {31'd0, o_valid}, 32'd0);
      chk("settle_ack", {31'd0, o_rate_ack}, {31'd0, (ack_last && k == n - 1)});
      repeat (gap) tick();
    end
  endtask

  initial begin
    // Reset held with a simultaneous rate-3 load.
    i_reset = 1'b1; i_rate_load = 1'b1; i_rate_sel = 2'd3;
    tick();
    tick();
    chk("rst_crst",  {31'd0, o_chain_reset}, 32'd1);
    chk("rst_en",    {29'd0, o_stage_en}, 32'd0);
    chk("rst_vld",   {31'd0, o_valid}, 32'd0);
    chk("rst_ack",   {31'd0, o_rate_ack}, 32'd0);
    chk("rst_drop",  {16'd0, o_drop_count}, 32'd0);
    chk("rst_inph",  {16'd0, o_inph_data}, 32'd0);
    chk("rst_busy",  {31'd0, o_busy}, 32'd1);

    i_reset = 1'b0; i_rate_load = 1'b0; i_rate_sel = 2'd0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("flush_crst", {31'd0, o_chain_reset}, {31'd0, (i < 4)});
      chk("z_busy",     {31'd0, z_busy}, {31'd0, (i < 5)});
      chk("z_ack",      {31'd0, z_rate_ack}, {31'd0, (i == 5)});
      tick();
    end
    chk("init_en", {29'd0, o_stage_en}, 32'd0);
    run_settle(16, 1, 1'b1);
    chk("run_ack_once", {31'd0, o_rate_ack}, 32'd0);
    chk("run_busy",     {31'd0, o_busy}, 32'd0);

    // RUN passthrough, one-cycle latency, data hold.
    i_valid = 1'b1; #1;
    chk("run_cin", {31'd0, o_chain_in_valid}, 32'd1);
    i_valid = 1'b0;
    send(16'h1234, 16'hABCD);
    chk("run_vld",  {31'd0, o_valid}, 32'd1);
    chk("run_inph", {16'd0, o_inph_data}, 32'h1234);
    chk("run_quad", {16'd0, o_quad_data}, 32'hABCD);
    tick();
    chk("hold_vld",  {31'd0, o_valid}, 32'd0);
    chk("hold_quad", {16'd0, o_quad_data}, 32'hABCD);

    // Rate 2 load in RUN with i_valid held and a cascade sample in the load cycle.
    i_rate_load = 1'b1; i_rate_sel = 2'd2; i_valid = 1'b1;
    i_chain_valid = 1'b1; i_chain_inph = 16'hBEEF; i_chain_quad = 16'hCAFE;
    #1;
    chk("load_cin", {31'd0, o_chain_in_valid}, 32'd1);
    tick();
    i_rate_load = 1'b0; i_chain_valid = 1'b0;
    chk("r2_en",       {29'd0, o_stage_en}, 32'b011);
    chk("discard_vld", {31'd0, o_valid}, 32'd0);
    chk("discard_dat", {16'd0, o_inph_data}, 32'h1234);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fl_cin",  {31'd0, o_chain_in_valid}, 32'd0);
      chk("fl_crst", {31'd0, o_chain_reset}, 32'd1);
      tick();
    end
    #1;
    chk("st_cin",  {31'd0, o_chain_in_valid}, 32'd1);
    chk("st_crst", {31'd0, o_chain_reset}, 32'd0);
    chk("drop4",   {16'd0, o_drop_count}, 32'd4);
    i_valid = 1'b0;
    run_settle(16, 3, 1'b1);
    send(16'h5A5A, 16'hA5A5);
    chk("s17_vld",  {31'd0, o_valid}, 32'd1);
    chk("s17_inph", {16'd0, o_inph_data}, 32'h5A5A);
    chk("s17_quad", {16'd0, o_quad_data}, 32'hA5A5);
    tick();
    chk("s17_end", {31'd0, o_valid}, 32'd0);

    // Reload aborting SETTLE after 10 pulses.
    i_rate_load = 1'b1; i_rate_sel = 2'd1;
    tick();
    i_rate_load = 1'b0;
    chk("r1_en", {29'd0, o_stage_en}, 32'b001);
    repeat (4) tick();
    run_settle(10, 1, 1'b0);
    i_rate_load = 1'b1; i_chain_valid = 1'b1;
    tick();
    i_rate_load = 1'b0; i_chain_valid = 1'b0;
    chk("abort_crst", {31'd0, o_chain_reset}, 32'd1);
    chk("abort_ack",  {31'd0, o_rate_ack}, 32'd0);
    repeat (4) tick();
    run_settle(16, 1, 1'b1);

    // Same rate reloaded in RUN still flushes.
    i_rate_load = 1'b1; i_rate_sel = 2'd1;
    tick();
    chk("same_crst", {31'd0, o_chain_reset}, 32'd1);
    chk("same_busy", {31'd0, o_busy}, 32'd1);

    // Continuous reloads with i_valid high drive the drop counter to saturation.
    i_rate_sel = 2'd3; i_valid = 1'b1;
    repeat (1000) tick();
    chk("drop1004", {16'd0, o_drop_count}, 32'd1004);
    chk("r3_en",    {29'd0, o_stage_en}, 32'b111);
    repeat (64530) tick();
    chk("drop_fffe", {16'd0, o_drop_count}, 32'hFFFE);
    tick();
    chk("drop_ffff", {16'd0, o_drop_count}, 32'hFFFF);
    repeat (10) tick();
    chk("drop_sat", {16'd0, o_drop_count}, 32'hFFFF);

    // Reset mid-operation overrides a simultaneous rate-3 load.
    i_reset = 1'b1; i_valid = 1'b0;
    tick();
    chk("mrst_en",   {29'd0, o_stage_en}, 32'd0);
    chk("mrst_drop", {16'd0, o_drop_count}, 32'd0);
    chk("mrst_inph", {16'd0, o_inph_data}, 32'd0);
    i_reset = 1'b0; i_rate_load = 1'b0;
    tick();
    chk("post_en",   {29'd0, o_stage_en}, 32'd0);
    chk("post_crst", {31'd0, o_chain_reset}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
